// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR input front end and the FIR core.
package fir_pkg;

  localparam int DATA_W       = 6;
  localparam int NUM_TAPS     = 4;
  localparam int COEFF_ADDR_W = $clog2(NUM_TAPS);

  typedef enum logic {
    STREAM = 1'b0,
    LOAD   = 1'b1
  } fir_in_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one raw pin plus a registered rising-edge detector.
// The chain and the history flop are preset to 1 so that a pin held high
// through reset is never seen as an edge.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // shift the raw pin through the synchroniser chain
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
    end
  end

  assign level = sync_q[STAGES-1];

  // one-cycle pulse when the synchronised level goes from 0 to 1
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= 1'b1;
      rise   <= 1'b0;
    end else begin
      hist_q <= level;
      rise   <= level & ~hist_q;
    end
  end

endmodule

// File: rtl/fir_input_framer.sv
// Pin-side front end of the FIR: synchronises ui_in, turns strobe edges into
// samples on a valid/ready stream, or into coefficient writes while loading.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   STREAM | strobed values go out on m_tdata/m_tvalid; mode rise -> LOAD
//   LOAD   | strobed values write taps 0..NUM_TAPS-1; mode low aborts
module fir_input_framer #(
  parameter int DATA_W      = fir_pkg::DATA_W,
  parameter int NUM_TAPS    = fir_pkg::NUM_TAPS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           pin_data,
  input  logic                        pin_strobe,
  input  logic                        pin_mode,
  output logic [DATA_W-1:0]           m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic                        coeff_we,
  output logic [$clog2(NUM_TAPS)-1:0] coeff_addr,
  output logic [DATA_W-1:0]           coeff_data,
  output logic                        loading,
  output logic                        overrun
);

  import fir_pkg::*;

  localparam int                ADDR_W    = $clog2(NUM_TAPS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TAPS - 1);

  logic [DATA_W-1:0] data_sync [SYNC_STAGES];
  logic [DATA_W-1:0] data_s;
  logic              str_level_unused;
  logic              str_evt;
  logic              mode_level;
  logic              mode_rise;
  fir_in_state_t     state;
  logic [ADDR_W-1:0] addr_cnt;
  logic              str_in_stream;
  logic              take_sample;
  logic              abort;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_strobe (
    .clk   (clk),
    .reset (reset),
    .pin   (pin_strobe),
    .level (str_level_unused),
    .rise  (str_evt)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mode (
    .clk   (clk),
    .reset (reset),
    .pin   (pin_mode),
    .level (mode_level),
    .rise  (mode_rise)
  );

  // plain synchroniser for the data pins, same depth as the strobe chain
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
    end else begin
      data_sync[0] <= pin_data;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
    end
  end

  assign data_s        = data_sync[SYNC_STAGES-1];
  assign abort         = (state == LOAD) && !mode_level;
  assign str_in_stream = (state == STREAM) && str_evt;
  assign take_sample   = str_in_stream && (!m_tvalid || m_tready);
  assign loading       = (state == LOAD);

  // mode FSM and coefficient write port; abort takes priority over a strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= STREAM;
      addr_cnt   <= '0;
      coeff_we   <= 1'b0;
      coeff_addr <= '0;
      coeff_data <= '0;
    end else begin
      coeff_we <= 1'b0;
      case (state)
        STREAM: begin
          if (mode_rise) begin
            state    <= LOAD;
            addr_cnt <= '0;
          end
        end
        LOAD: begin
          if (abort) begin
            state    <= STREAM;
            addr_cnt <= '0;
          end else if (str_evt) begin
            coeff_we   <= 1'b1;
            coeff_addr <= addr_cnt;
            coeff_data <= data_s;
            if (addr_cnt == LAST_ADDR) begin
              state    <= STREAM;
              addr_cnt <= '0;
            end else begin
              addr_cnt <= addr_cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= STREAM;
          addr_cnt <= '0;
        end
      endcase
    end
  end

  // one-deep output register; a strobe that finds it full and stalled is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (take_sample) begin
        m_tdata  <= data_s;
        m_tvalid <= 1'b1;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
      if (str_in_stream && m_tvalid && !m_tready) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_input_framer.sv
// Randomised scoreboard bench for fir_input_framer. A reference model derives
// events from the recorded pin history using the documented latencies and
// pushes expected transfers/writes; a negedge monitor pops and compares.
module tb_fir_input_framer;

  localparam int DW = 6;
  localparam int NT = 4;
  localparam int AW = 2;
  localparam int HN = 8192;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] pin_data;
  logic          pin_strobe;
  logic          pin_mode;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          coeff_we;
  logic [AW-1:0] coeff_addr;
  logic [DW-1:0] coeff_data;
  logic          loading;
  logic          overrun;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;

  fir_input_framer dut (
    .clk        (clk),
    .reset      (reset),
    .pin_data   (pin_data),
    .pin_strobe (pin_strobe),
    .pin_mode   (pin_mode),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .coeff_we   (coeff_we),
    .coeff_addr (coeff_addr),
    .coeff_data (coeff_data),
    .loading    (loading),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  logic          str_h  [HN];
  logic          mode_h [HN];
  logic [DW-1:0] data_h [HN];
  int            edge_n   = 0;
  int            last_rst = -1;

  logic          mv = 1'b0, ovr = 1'b0, ld = 1'b0, cwe = 1'b0;
  logic [DW-1:0] md = '0;
  int            cnt = 0;
  logic [DW-1:0]    exp_s [$];
  logic [AW+DW-1:0] exp_c [$];

  int            mn;
  logic          m_ev, m_mr, m_ml;
  logic [DW-1:0] m_dv;

  // synchronised view of a control pin as sampled at edge k (reset presets to 1)
  function automatic logic ctl_at(input bit is_mode, input int k);
    if (k < 0 || k <= last_rst) return 1'b1;
    return is_mode ? mode_h[k] : str_h[k];
  endfunction

  always @(posedge clk) begin
    mn = edge_n;
    if (mn >= HN) begin
      $display("FAIL history_overflow actual=%0d required<%0d", mn, HN);
      $fatal(1);
    end
    str_h[mn]  = pin_strobe;
    mode_h[mn] = pin_mode;
    data_h[mn] = pin_data;
    cwe = 1'b0;
    if (reset) begin
      last_rst = mn;
      mv = 1'b0; md = '0; ovr = 1'b0; ld = 1'b0; cnt = 0;
      exp_s.delete();
      exp_c.delete();
    end else begin
      // value strobed at edge j acts at edge j+3; mode level is seen 2 edges late
      m_ev = ctl_at(0, mn-3) && !ctl_at(0, mn-4);
      m_mr = ctl_at(1, mn-3) && !ctl_at(1, mn-4);
      m_ml = ctl_at(1, mn-2);
      m_dv = (mn-2 <= last_rst) ? '0 : data_h[mn-2];
      if (!ld && m_ev) begin
        if (!mv || m_tready) begin
          mv = 1'b1;
          md = m_dv;
          exp_s.push_back(m_dv);
        end else begin
          ovr = 1'b1;
        end
      end else if (m_tready) begin
        mv = 1'b0;
      end
      if (!ld) begin
        if (m_mr) begin ld = 1'b1; cnt = 0; end
      end else if (!m_ml) begin
        ld = 1'b0; cnt = 0;
      end else if (m_ev) begin
        cwe = 1'b1;
        exp_c.push_back({AW'(cnt), m_dv});
        if (cnt == NT-1) begin ld = 1'b0; cnt = 0; end
        else cnt = cnt + 1;
      end
    end
    edge_n = mn + 1;
  end

  // ---------------- monitor ----------------
  logic [DW-1:0]    pop_s;
  logic [AW+DW-1:0] pop_c;

  always @(negedge clk) begin
    chk("status{valid,loading,overrun,we}", {28'b0, m_tvalid, loading, overrun, coeff_we},
        {28'b0, mv, ld, ovr, cwe});
    if (m_tvalid) chk("tdata_held", {26'b0, m_tdata}, {26'b0, md});
    if (m_tvalid && m_tready) begin
      checks++;
      if (exp_s.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected actual=%0h required=none at %0t", m_tdata, $time);
      end else begin
        pop_s = exp_s.pop_front();
        if (m_tdata !== pop_s) begin
          errors++;
          $display("FAIL xfer_data actual=%0h required=%0h at %0t", m_tdata, pop_s, $time);
        end
      end
    end
    if (coeff_we) begin
      checks++;
      if (exp_c.size() == 0) begin
        errors++;
        $display("FAIL coeff_unexpected actual=%0h/%0h required=none at %0t", coeff_addr, coeff_data, $time);
      end else begin
        pop_c = exp_c.pop_front();
        if ({coeff_addr, coeff_data} !== pop_c) begin
          errors++;
          $display("FAIL coeff_write actual=%0h required=%0h at %0t", {coeff_addr, coeff_data}, pop_c, $time);
        end
      end
    end
  end

  // ---------------- ready driver ----------------
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'b0;
        default: m_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [DW-1:0] d, input int hi, input int lo);
    pin_data = d;
    tick(2);
    pin_strobe = 1'b1;
    tick(hi);
    pin_strobe = 1'b0;
    tick(lo);
  endtask

  task automatic pulse_expect_valid(input logic [DW-1:0] d, input string name);
    pin_data = d;
    tick(2);
    pin_strobe = 1'b1;
    tick(1);
    pin_strobe = 1'b0;
    tick(2);
    chk({name, "_early"}, {31'b0, m_tvalid}, 32'd0);
    tick(1);
    chk({name, "_valid"}, {31'b0, m_tvalid}, 32'd1);
    chk({name, "_data"}, {26'b0, m_tdata}, {26'b0, d});
    tick(2);
  endtask

  task automatic pulse_expect_we(input logic [DW-1:0] d, input logic [AW-1:0] a, input string name);
    pin_data = d;
    tick(2);
    pin_strobe = 1'b1;
    tick(1);
    pin_strobe = 1'b0;
    tick(2);
    chk({name, "_early"}, {31'b0, coeff_we}, 32'd0);
    tick(1);
    chk({name, "_we"}, {31'b0, coeff_we}, 32'd1);
    chk({name, "_addr"}, {30'b0, coeff_addr}, {30'b0, a});
    chk({name, "_data"}, {26'b0, coeff_data}, {26'b0, d});
    tick(2);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_tdata"}, {26'b0, m_tdata}, 32'd0);
    chk({name, "_tvalid"}, {31'b0, m_tvalid}, 32'd0);
    chk({name, "_we"}, {31'b0, coeff_we}, 32'd0);
    chk({name, "_addr"}, {30'b0, coeff_addr}, 32'd0);
    chk({name, "_cdata"}, {26'b0, coeff_data}, 32'd0);
    chk({name, "_loading"}, {31'b0, loading}, 32'd0);
    chk({name, "_overrun"}, {31'b0, overrun}, 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    pin_data   = '0;
    pin_strobe = 1'b0;
    pin_mode   = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check_all_zero("reset");

    // stream sample with latency check
    rdy_mode = 0;
    tick(2);
    pulse_expect_valid(6'h2A, "stream");
    chk("stream_overrun", {31'b0, overrun}, 32'd0);

    // backpressure: second sample dropped, first held
    rdy_mode = 1;
    tick(2);
    strobe(6'h05, 1, 3);
    strobe(6'h11, 1, 4);
    chk("bp_tdata", {26'b0, m_tdata}, 32'h05);
    chk("bp_tvalid", {31'b0, m_tvalid}, 32'd1);
    chk("bp_overrun", {31'b0, overrun}, 32'd1);
    rdy_mode = 0;
    tick(3);
    chk("bp_drained", {31'b0, m_tvalid}, 32'd0);

    // full load, mode left high afterwards
    pin_mode = 1'b1;
    tick(5);
    chk("load_entry", {31'b0, loading}, 32'd1);
    pulse_expect_we(6'h01, 2'd0, "load0");
    pulse_expect_we(6'h02, 2'd1, "load1");
    pulse_expect_we(6'h03, 2'd2, "load2");
    pulse_expect_we(6'h04, 2'd3, "load3");
    chk("load_exit", {31'b0, loading}, 32'd0);
    pulse_expect_valid(6'h3F, "post_load");

    // abort after two taps, restart writes at addr 0
    pin_mode = 1'b0;
    tick(4);
    pin_mode = 1'b1;
    tick(5);
    pulse_expect_we(6'h07, 2'd0, "abort_w0");
    pulse_expect_we(6'h08, 2'd1, "abort_w1");
    pin_mode = 1'b0;
    tick(4);
    chk("abort_loading", {31'b0, loading}, 32'd0);
    pin_mode = 1'b1;
    tick(5);
    pulse_expect_we(6'h09, 2'd0, "restart_w0");

    // abort coinciding with a strobe event: no write
    pin_data = 6'h15;
    tick(2);
    pin_strobe = 1'b1;
    tick(1);
    pin_mode = 1'b0;
    tick(1);
    pin_strobe = 1'b0;
    tick(5);
    chk("coinc_loading", {31'b0, loading}, 32'd0);
    chk("coinc_no_write", {26'b0, coeff_data}, 32'h09);

    // reset with strobe held high and a pending sample
    rdy_mode = 1;
    tick(2);
    strobe(6'h2C, 1, 4);
    chk("pre_reset_pending", {31'b0, m_tvalid}, 32'd1);
    pin_strobe = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    rdy_mode = 0;
    tick(6);
    check_all_zero("held_reset");
    pin_strobe = 1'b0;
    tick(3);
    pulse_expect_valid(6'h33, "after_reset");

    // randomised traffic
    rdy_mode = 2;
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 70)      strobe(DW'($urandom), $urandom_range(1, 3), $urandom_range(1, 3));
      else if (r < 80) begin pin_mode = 1'b1; tick($urandom_range(1, 4)); end
      else if (r < 92) begin pin_mode = 1'b0; tick($urandom_range(1, 4)); end
      else if (r < 97) tick($urandom_range(1, 5));
      else begin reset = 1'b1; tick($urandom_range(1, 2)); reset = 1'b0; end
    end

    rdy_mode   = 0;
    pin_mode   = 1'b0;
    pin_strobe = 1'b0;
    tick(10);
    chk("sb_samples_left", exp_s.size(), 32'd0);
    chk("sb_coeffs_left", exp_c.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_input_framer.md
# fir_input_framer

Input-side front end for the FIR datapath. It synchronises the raw `ui_in` pins, turns strobe edges into single samples, and runs a small state machine. In stream mode it presents 6-bit samples on a valid/ready output to the filter. In load mode it steers successive strobed values into the filter's coefficient registers. It sits between the top-level pin mapping and the `FIR` instance; it replaces the direct wiring of `ui_in[5:0]`, `ui_in[6]` and `ui_in[7]`.

## Interface
Parameters:
- `DATA_W`, 6: sample and coefficient width.
- `NUM_TAPS`, 4: number of coefficients written per load sequence.
- `SYNC_STAGES`, 2: synchroniser depth; minimum 2.

Ports:
- `clk`, in, 1: single clock; everything is on its rising edge.
- `reset`, in, 1: synchronous, active-high; clears all state.
- `pin_data`, in, DATA_W: raw sample or coefficient value, fed from `ui_in[5:0]`.
- `pin_strobe`, in, 1: raw strobe; its rising edge marks one value. Fed from `ui_in[6]`.
- `pin_mode`, in, 1: raw mode; rising edge starts a load, low level ends it. Fed from `ui_in[7]`.
- `m_tdata`, out, DATA_W: sample to the FIR.
- `m_tvalid`, out, 1: sample valid.
- `m_tready`, in, 1: FIR accepts the sample.
- `coeff_we`, out, 1: one-cycle coefficient write pulse.
- `coeff_addr`, out, clog2(NUM_TAPS): tap index being written.
- `coeff_data`, out, DATA_W: coefficient value.
- `loading`, out, 1: high while in the LOAD state.
- `overrun`, out, 1: sticky; a sample was dropped. Cleared only by reset.

## Operation
- **Synchronisers:** all DATA_W+2 pins pass through SYNC_STAGES flops.
- **Strobe event:** `str_evt` is high when the synchronised strobe is 1 and its history flop is 0.
- **Mode event:** `mode_rise` is formed the same way from the synchronised mode.
- **History flops reset to 1.** A pin held high through reset therefore produces no event.
- **FSM states:** STREAM (reset state) and LOAD.
- **STREAM, on `str_evt`:**
  - If `m_tvalid`=0 or `m_tready`=1: load `m_tdata` with the synchronised data and set `m_tvalid`.
  - Otherwise: drop the sample, leave `m_tdata` unchanged, set `overrun`.
- **STREAM, `mode_rise`:** go to LOAD and clear the address counter to 0.
- **LOAD, on `str_evt`:**
  - Pulse `coeff_we` for one cycle with `coeff_data` = synchronised data and `coeff_addr` = counter.
  - Increment the counter.
  - The write at index NUM_TAPS-1 returns the FSM to STREAM in the same cycle.
- **LOAD, synchronised mode = 0:** abort to STREAM and clear the counter.
  - Taps already written keep their new values; the rest are untouched.
  - If abort and `str_evt` coincide, the abort wins and no write occurs.
- **Mode still high after a completed load:** stay in STREAM until the next `mode_rise`.
- **Output handshake in both states:**
  - A pending sample stays valid in LOAD and drains normally.
  - `m_tvalid` clears on `m_tready` unless a new sample loads in the same cycle; a concurrent load keeps `m_tvalid` high and is not an overrun.
  - `m_tdata` holds stable while `m_tvalid`=1 and `m_tready`=0.
- **Reset values:** `m_tdata`=0, `m_tvalid`=0, `coeff_we`=0, `coeff_addr`=0, `coeff_data`=0, `loading`=0, `overrun`=0.

## Timing
- **Output registers:** all outputs are registered; no combinational path from `m_tready` to any output.
- **Event latency:** the first edge that samples `pin_strobe`=1 is edge 0. `m_tvalid`, or `coeff_we`, is high after edge SYNC_STAGES+1, i.e. edge 3 with the defaults.
- **Data alignment:** `pin_data` passes through the same synchroniser depth as the strobe. It must be stable from SYNC_STAGES cycles before to 1 cycle after the strobe rise.
- **Strobe pulse width:** minimum 1 clock high and 1 clock low between events. Faster toggling gives an undefined event count.
- **LOAD entry:** `loading` rises SYNC_STAGES+1 edges after `pin_mode` rises.
- **LOAD exit:** `loading` falls on the edge that registers the final `coeff_we`, or the abort.
- **Throughput:** one sample per 2 clocks maximum (strobe-limited).
- **Mid-operation reset:** takes effect on the next edge; a partial load is abandoned and a pending sample is discarded.

## Structure
- **Package `fir_pkg`:**
  - `DATA_W` and `NUM_TAPS` defaults, shared with `FIR`.
  - State enum `fir_in_state_t` {STREAM, LOAD}.
  - `COEFF_ADDR_W` = clog2(NUM_TAPS).
- **Sub-module `sync_edge`:** a SYNC_STAGES-deep synchroniser plus a rising-edge detector with reset-to-1 history, outputs `level` and `rise`.
  - Instantiated once for strobe and once for mode.
  - Data uses plain synchroniser flops.

## Test plan
- **Stream sample:** reset, then `pin_data`=6'h2A with a strobe pulse and `m_tready`=1 → `m_tvalid` high for 1 cycle after edge 3, `m_tdata`=6'h2A, `overrun`=0.
- **Backpressure:** `m_tready`=0, strobe 6'h05 then 6'h11 → `m_tdata` stays 6'h05 with `m_tvalid` held and `overrun`=1. Raise `m_tready` → one transfer of 6'h05, then `m_tvalid`=0.
- **Full load:** `pin_mode` rises, then strobe 6'h01, 6'h02, 6'h03, 6'h04 → four `coeff_we` pulses with addr 0..3 and matching data. `loading` falls with the fourth write; the next strobe yields `m_tvalid`.
- **Abort:** two coefficients loaded, then `pin_mode` low → `loading` 0 and counter 0. A new `mode_rise` writes next at addr 0.
- **Reset with strobe held high:** reset asserted with strobe held high and pending `m_tvalid` → after reset all outputs are 0 and no event fires until the strobe goes low then high again.
